// File: rtl/ps2_scan_capture_if.sv
// Signal bundle between the PS/2 capture front end and the scancode display stage.
// The master side samples the raw PS/2 lines and drives the decoded key state.
interface ps2_scan_capture_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] my_data;
  logic       predata;
  logic       code_valid;
  logic       frame_err;
  logic [7:0] press_count;

  modport master (
    input  ps2_clk,
    input  ps2_data,
    output my_data,
    output predata,
    output code_valid,
    output frame_err,
    output press_count
  );

  modport slave (
    output ps2_clk,
    output ps2_data,
    input  my_data,
    input  predata,
    input  code_valid,
    input  frame_err,
    input  press_count
  );
endinterface

// File: rtl/ps2_scan_capture.sv
// PS/2 keyboard front end: deserialises device-to-host frames and tracks
// make/break sequences into a latest-code, key-held flag and press counter.
module ps2_scan_capture #(
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                clk,
  input  logic                clrn,
  ps2_scan_capture_if.master  bus
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] data_sync_r;
  state_t                 state_r;
  state_t                 state_s;
  logic [3:0]             bitcnt_r;
  logic [9:0]             shift_r;
  logic [TO_W-1:0]        timeout_r;
  logic                   break_pending_r;
  logic [7:0]             my_data_r;
  logic                   predata_r;
  logic                   code_valid_r;
  logic                   frame_err_r;
  logic [7:0]             press_count_r;
  logic                   fall_s;
  logic                   sdata_s;
  logic                   timeout_hit_s;
  logic                   frame_ok_s;
  logic [7:0]             code_s;

  assign fall_s  = (clk_sync_r[SYNC_STAGES-1 -: 2] == 2'b10);
  assign sdata_s = data_sync_r[SYNC_STAGES-1];
  assign code_s  = shift_r[7:0];

  // Synchronise the asynchronous PS/2 lines; idle line level is high
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_r  <= {SYNC_STAGES{1'b1}};
      data_sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], bus.ps2_clk};
      data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], bus.ps2_data};
    end
  end

  // Frame state register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic, frame validity and inactivity timeout detection
  always_comb begin
    state_s       = state_r;
    timeout_hit_s = 1'b0;
    frame_ok_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (fall_s && !sdata_s) begin
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (fall_s) begin
          if (bitcnt_r == 4'd10) begin
            state_s = CHECK;
          end else begin
            state_s = SHIFT;
          end
        end else if (timeout_r == TO_W'(TIMEOUT_CYC - 1)) begin
          timeout_hit_s = 1'b1;
          state_s       = IDLE;
        end else begin
          state_s = SHIFT;
        end
      end
      CHECK: begin
        state_s    = IDLE;
        frame_ok_s = odd_parity_ok(shift_r[7:0], shift_r[8]) && shift_r[9];
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Bit capture, timeout counter and decoded key state
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bitcnt_r        <= 4'd0;
      shift_r         <= 10'd0;
      timeout_r       <= {TO_W{1'b0}};
      break_pending_r <= 1'b0;
      my_data_r       <= 8'h00;
      predata_r       <= 1'b0;
      code_valid_r    <= 1'b0;
      frame_err_r     <= 1'b0;
      press_count_r   <= 8'd0;
    end else begin
      code_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          timeout_r <= {TO_W{1'b0}};
          if (fall_s && !sdata_s) begin
            bitcnt_r <= 4'd1;
          end
        end
        SHIFT: begin
          if (fall_s) begin
            shift_r   <= {sdata_s, shift_r[9:1]};
            bitcnt_r  <= bitcnt_r + 4'd1;
            timeout_r <= {TO_W{1'b0}};
          end else if (timeout_hit_s) begin
            bitcnt_r    <= 4'd0;
            timeout_r   <= {TO_W{1'b0}};
            frame_err_r <= 1'b1;
          end else begin
            timeout_r <= timeout_r + {{(TO_W-1){1'b0}}, 1'b1};
          end
        end
        CHECK: begin
          bitcnt_r  <= 4'd0;
          timeout_r <= {TO_W{1'b0}};
          if (!frame_ok_s) begin
            frame_err_r <= 1'b1;
          end else begin
            code_valid_r <= 1'b1;
            // F0 arms a break, E0 is a prefix that carries no key information
            if (code_s == 8'hF0) begin
              break_pending_r <= 1'b1;
            end else if (code_s == 8'hE0) begin
              break_pending_r <= break_pending_r;
            end else if (break_pending_r) begin
              my_data_r       <= code_s;
              predata_r       <= 1'b0;
              break_pending_r <= 1'b0;
            end else begin
              if (!predata_r || (code_s != my_data_r)) begin
                press_count_r <= press_count_r + 8'd1;
              end
              my_data_r <= code_s;
              predata_r <= 1'b1;
            end
          end
        end
        default: begin
          bitcnt_r  <= 4'd0;
          timeout_r <= {TO_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.my_data     = my_data_r;
  assign bus.predata     = predata_r;
  assign bus.code_valid  = code_valid_r;
  assign bus.frame_err   = frame_err_r;
  assign bus.press_count = press_count_r;

endmodule

// File: tb/tb_ps2_scan_capture.sv
// Bench for ps2_scan_capture: table of frames with hand-derived results, a
// timeout / mid-frame reset sequence and a 256-press counter wrap run.
module tb_ps2_scan_capture;

  localparam int HALF = 3;
  localparam int TO   = 2000;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
    logic       held;
    logic [7:0] cnt;
  } res_t;

  typedef struct {
    string      name;
    logic [7:0] code;
    bit         bad_par;
    bit         bad_stop;
    res_t       exp;
  } vec_t;

  logic clk  = 1'b0;
  logic clrn = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  res_t exp_q[$];
  res_t obs_q[$];
  vec_t vecs[16];

  always #5 clk = ~clk;

  ps2_scan_capture_if bus_if ();

  ps2_scan_capture #(
    .SYNC_STAGES (3),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus_if.master)
  );

  // Record every status pulse with the outputs visible alongside it
  always @(negedge clk) begin
    if (clrn && (bus_if.code_valid || bus_if.frame_err)) begin
      obs_q.push_back({bus_if.frame_err, bus_if.my_data, bus_if.predata, bus_if.press_count});
    end
  end

  function automatic res_t mk_res(input logic err, input logic [7:0] data,
                                  input logic held, input logic [7:0] cnt);
    res_t r;
    r.err  = err;
    r.data = data;
    r.held = held;
    r.cnt  = cnt;
    return r;
  endfunction

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par,
                                           input bit bad_stop);
    logic par;
    par = (~^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  task automatic ps2_bit(input logic b);
    bus_if.ps2_data = b;
    repeat (HALF) @(posedge clk);
    bus_if.ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    bus_if.ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) ps2_bit(frame[i]);
    bus_if.ps2_data = 1'b1;
  endtask

  task automatic check(input string name, input res_t got, input res_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got err=%0b data=%h held=%0b cnt=%0d, want err=%0b data=%h held=%0b cnt=%0d",
               name, got.err, got.data, got.held, got.cnt, exp.err, exp.data, exp.held, exp.cnt);
    end
  endtask

  task automatic expect_result(input string name, input int budget);
    res_t e;
    res_t g;
    int   k;
    e = exp_q.pop_front();
    k = 0;
    while (obs_q.size() == 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (obs_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no status pulse within %0d cycles, want err=%0b data=%h",
               name, budget, e.err, e.data);
    end else begin
      g = obs_q.pop_front();
      check(name, g, e);
    end
  endtask

  task automatic send_code(input string name, input logic [7:0] b, input bit bad_par,
                           input bit bad_stop, input res_t exp);
    exp_q.push_back(exp);
    send_bits(mk_frame(b, bad_par, bad_stop), 11);
    expect_result(name, 40);
    repeat (2 * HALF) @(posedge clk);
  endtask

  initial begin
    logic [7:0] code;
    logic [7:0] cnt;

    vecs[0]  = '{"make_1c",     8'h1C, 1'b0, 1'b0, mk_res(1'b0, 8'h1C, 1'b1, 8'd1)};
    vecs[1]  = '{"typematic_1", 8'h1C, 1'b0, 1'b0, mk_res(1'b0, 8'h1C, 1'b1, 8'd1)};
    vecs[2]  = '{"typematic_2", 8'h1C, 1'b0, 1'b0, mk_res(1'b0, 8'h1C, 1'b1, 8'd1)};
    vecs[3]  = '{"typematic_3", 8'h1C, 1'b0, 1'b0, mk_res(1'b0, 8'h1C, 1'b1, 8'd1)};
    vecs[4]  = '{"f0_prefix",   8'hF0, 1'b0, 1'b0, mk_res(1'b0, 8'h1C, 1'b1, 8'd1)};
    vecs[5]  = '{"break_1c",    8'h1C, 1'b0, 1'b0, mk_res(1'b0, 8'h1C, 1'b0, 8'd1)};
    vecs[6]  = '{"remake_1c",   8'h1C, 1'b0, 1'b0, mk_res(1'b0, 8'h1C, 1'b1, 8'd2)};
    vecs[7]  = '{"make_32",     8'h32, 1'b0, 1'b0, mk_res(1'b0, 8'h32, 1'b1, 8'd3)};
    vecs[8]  = '{"e0_prefix",   8'hE0, 1'b0, 1'b0, mk_res(1'b0, 8'h32, 1'b1, 8'd3)};
    vecs[9]  = '{"make_75",     8'h75, 1'b0, 1'b0, mk_res(1'b0, 8'h75, 1'b1, 8'd4)};
    vecs[10] = '{"bad_parity",  8'h1C, 1'b1, 1'b0, mk_res(1'b1, 8'h75, 1'b1, 8'd4)};
    vecs[11] = '{"bad_stop",    8'h1C, 1'b0, 1'b1, mk_res(1'b1, 8'h75, 1'b1, 8'd4)};
    vecs[12] = '{"f0_again",    8'hF0, 1'b0, 1'b0, mk_res(1'b0, 8'h75, 1'b1, 8'd4)};
    vecs[13] = '{"bad_in_brk",  8'h5A, 1'b1, 1'b0, mk_res(1'b1, 8'h75, 1'b1, 8'd4)};
    vecs[14] = '{"break_75",    8'h75, 1'b0, 1'b0, mk_res(1'b0, 8'h75, 1'b0, 8'd4)};
    vecs[15] = '{"make_29",     8'h29, 1'b0, 1'b0, mk_res(1'b0, 8'h29, 1'b1, 8'd5)};

    bus_if.ps2_clk  = 1'b1;
    bus_if.ps2_data = 1'b1;
    clrn = 1'b0;
    repeat (4) @(posedge clk);
    clrn = 1'b1;
    @(negedge clk);
    check("reset_state",
          {bus_if.code_valid | bus_if.frame_err, bus_if.my_data, bus_if.predata, bus_if.press_count},
          mk_res(1'b0, 8'h00, 1'b0, 8'd0));
    repeat (4) @(posedge clk);

    for (int i = 0; i < 16; i++) begin
      send_code(vecs[i].name, vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop, vecs[i].exp);
    end

    // Start bit plus four data bits, then silence until the timeout fires
    exp_q.push_back(mk_res(1'b1, 8'h29, 1'b1, 8'd5));
    send_bits(mk_frame(8'h5A, 1'b0, 1'b0), 5);
    expect_result("timeout", TO + 100);
    repeat (2 * HALF) @(posedge clk);
    send_code("after_timeout", 8'h29, 1'b0, 1'b0, mk_res(1'b0, 8'h29, 1'b1, 8'd5));

    // Reset in the middle of a frame: start bit plus five data bits sent
    send_bits(mk_frame(8'h66, 1'b0, 1'b0), 6);
    @(posedge clk);
    #1 clrn = 1'b0;
    #1;
    check("midframe_reset",
          {bus_if.code_valid | bus_if.frame_err, bus_if.my_data, bus_if.predata, bus_if.press_count},
          mk_res(1'b0, 8'h00, 1'b0, 8'd0));
    repeat (4) @(posedge clk);
    clrn = 1'b1;
    repeat (4) @(posedge clk);

    // 256 make/break presses from reset; the counter must wrap back to zero
    for (int i = 0; i < 256; i++) begin
      code = 8'h10 + 8'(i % 64);
      cnt  = 8'(i + 1);
      send_code("wrap_make",  code,  1'b0, 1'b0, mk_res(1'b0, code, 1'b1, cnt));
      send_code("wrap_f0",    8'hF0, 1'b0, 1'b0, mk_res(1'b0, code, 1'b1, cnt));
      send_code("wrap_break", code,  1'b0, 1'b0, mk_res(1'b0, code, 1'b0, cnt));
    end
    @(negedge clk);
    n_tests++;
    if (bus_if.press_count !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_final: press_count=%0d, want 0", bus_if.press_count);
    end

    repeat (10) @(posedge clk);
    n_tests++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL spurious_pulses: %0d unexpected status pulses, want 0", obs_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
